// File: rtl/wb_pkg.sv
// Shared widths, constants and write-request type for the register-file writeback path.
package wb_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REQ  = 3;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Zero latency; stall forces an all-zero grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               stall,
  output logic [NUM_REQ-1:0] grant
);
  int               idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!stall && !found && valid[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter with a one-entry registered output stage (1 cycle grant-to-write).
// Optional read bypass from the output stage when WB_BYPASS_EN is defined; ctrl_stall or reset blocks all grants.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = wb_pkg::NUM_REQ,
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int ADDR_W  = wb_pkg::ADDR_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      ctrl_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         ctrl_readRegA,
  input  logic [ADDR_W-1:0]         ctrl_readRegB,
  output logic                      fwd_hitA,
  output logic                      fwd_hitB,
  output logic [DATA_W-1:0]         fwd_dataA,
  output logic [DATA_W-1:0]         fwd_dataB
`endif
);
  import wb_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic               arb_block;
  logic [NUM_REQ-1:0] grant;

  // While reset is held no requester may see a ready, even though flops are already clear.
  assign arb_block = ctrl_stall | ~ctrl_reset;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (ptr_q),
    .stall (arb_block),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ptr_d  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        wreg_d = req_reg[i*ADDR_W +: ADDR_W];
        wdat_d = req_data[i*DATA_W +: DATA_W];
        we_d   = (req_reg[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      wreg_q <= '0;
      wdat_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      wreg_q <= wreg_d;
      wdat_q <= wdat_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdat_q;

`ifdef WB_BYPASS_EN
  // we_q is never set for register 0, so a read of r0 cannot hit.
  assign fwd_hitA  = we_q && (ctrl_readRegA == wreg_q);
  assign fwd_hitB  = we_q && (ctrl_readRegB == wreg_q);
  assign fwd_dataA = fwd_hitA ? wdat_q : '0;
  assign fwd_dataB = fwd_hitB ? wdat_q : '0;
`endif
endmodule
